// File: rtl/mul_pkg.sv
// ---------------------------------------------------------------------------
// mul_pkg
// Shared constants and types for the sequential shift-add multiplier.
//   WIDTH      : operand width in bits
//   PROD_WIDTH : product width (2 * WIDTH)
//   CNT_WIDTH  : iteration counter width, wide enough to hold WIDTH itself
//   state_t    : multiplier control states
// ---------------------------------------------------------------------------
package mul_pkg;

  localparam int WIDTH      = 24;
  localparam int PROD_WIDTH = 2 * WIDTH;
  localparam int CNT_WIDTH  = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_multiplier.sv
// ---------------------------------------------------------------------------
// seq_multiplier
// Multi-cycle WIDTH x WIDTH shift-add multiplier feeding the CPU's mul result
// register. One partial product is folded in per clock; signed operands are
// handled by multiplying magnitudes and negating the result at the end.
//
// Ports:
//   Clock     in   rising-edge clock
//   Reset_n   in   asynchronous active-low reset
//   Start     in   request a multiply (sampled only in IDLE)
//   Signed    in   1 = two's-complement operands, 0 = unsigned
//   OperandA  in   multiplicand
//   OperandB  in   multiplier
//   Busy      out  high whenever the unit is not IDLE
//   Done      out  one-cycle pulse when WriteMul carries a new product
//   MulWrite  out  write strobe for the mul register, identical to Done
//   WriteMul  out  product, held until the next completion
// ---------------------------------------------------------------------------
module seq_multiplier
  import mul_pkg::*;
(
  input  logic                  Clock,
  input  logic                  Reset_n,
  input  logic                  Start,
  input  logic                  Signed,
  input  logic [WIDTH-1:0]      OperandA,
  input  logic [WIDTH-1:0]      OperandB,
  output logic                  Busy,
  output logic                  Done,
  output logic                  MulWrite,
  output logic [PROD_WIDTH-1:0] WriteMul
);

  localparam logic [CNT_WIDTH-1:0] CNT_INIT = CNT_WIDTH'(WIDTH);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  state_t                r_state;
  state_t                w_stateNext;

  logic [WIDTH-1:0]      r_multiplicand;
  logic [WIDTH-1:0]      r_multiplier;
  logic                  r_sign;
  logic [CNT_WIDTH-1:0]  r_count;
  logic [PROD_WIDTH:0]   r_acc;
  logic [PROD_WIDTH-1:0] r_product;

  logic [WIDTH-1:0]      w_magA;
  logic [WIDTH-1:0]      w_magB;
  logic [WIDTH-1:0]      w_addend;
  logic [WIDTH:0]        w_sum;
  logic [PROD_WIDTH:0]   w_accShifted;
  logic [PROD_WIDTH-1:0] w_result;

  // Magnitude of each operand in signed mode. The most negative value maps
  // onto 2^(WIDTH-1), which still fits as an unsigned WIDTH-bit number.
  assign w_magA = (Signed && OperandA[WIDTH-1]) ? -OperandA : OperandA;
  assign w_magB = (Signed && OperandB[WIDTH-1]) ? -OperandB : OperandB;

  // One shift-add step: add the multiplicand into the upper half when the
  // multiplier LSB is set, keeping the carry in the extra top bit, then shift
  // the whole accumulator right by one.
  assign w_addend     = r_multiplier[0] ? r_multiplicand : '0;
  assign w_sum        = r_acc[PROD_WIDTH:WIDTH] + {1'b0, w_addend};
  assign w_accShifted = {1'b0, w_sum, r_acc[WIDTH-1:1]};

  // Negating zero yields zero, so a signed zero product never turns negative.
  assign w_result = r_sign ? -r_acc[PROD_WIDTH-1:0] : r_acc[PROD_WIDTH-1:0];

  // State register.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state and state-decoded outputs. RUN holds until the counter has
  // drained to zero, which gives WIDTH iterations plus the cycle that
  // observes the empty counter and launches the final result into DONE.
  always_comb begin
    w_stateNext = r_state;
    Busy        = 1'b0;
    Done        = 1'b0;
    case (r_state)
      IDLE: begin
        if (Start) begin
          w_stateNext = RUN;
        end
      end
      RUN: begin
        Busy = 1'b1;
        if (r_count == '0) begin
          w_stateNext = DONE;
        end
      end
      DONE: begin
        Busy        = 1'b1;
        Done        = 1'b1;
        w_stateNext = IDLE;
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  assign MulWrite = Done;
  assign WriteMul = r_product;

  // Datapath: capture operands in IDLE, iterate in RUN, and update the held
  // product only on the transition into DONE so it stays stable otherwise.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_multiplicand <= '0;
      r_multiplier   <= '0;
      r_sign         <= 1'b0;
      r_count        <= '0;
      r_acc          <= '0;
      r_product      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (Start) begin
            r_multiplicand <= w_magA;
            r_multiplier   <= w_magB;
            r_sign         <= Signed & (OperandA[WIDTH-1] ^ OperandB[WIDTH-1]);
            r_count        <= CNT_INIT;
            r_acc          <= '0;
          end
        end
        RUN: begin
          if (r_count != '0) begin
            r_acc        <= w_accShifted;
            r_multiplier <= r_multiplier >> 1;
            r_count      <= r_count - CNT_ONE;
          end else begin
            r_product <= w_result;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
